cmd_link: RTL and testbench

CMD_LINK -- requirements
Module: cmd_link

---
 rtl/cmd_link_if.sv | 24 ++
 rtl/cmd_link.sv | 177 +++++++++++++++++
 tb/tb_cmd_link.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_link_if.sv
// Command-link bundle: serial lines plus the command/response handshake
// between cmd_link and its host-side consumer.
interface cmd_link_if;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;

  // Host / consumer side
  modport master (
    output RX, clr_cmd_rdy, trmt, resp,
    input  TX, cmd, cmd_rdy, tx_done
  );

  // cmd_link side
  modport slave (
    input  RX, clr_cmd_rdy, trmt, resp,
    output TX, cmd, cmd_rdy, tx_done
  );
endinterface

// File: rtl/cmd_link.sv
// cmd_link: UART command receiver that pairs two received bytes into a
// 16-bit command {high, low}, plus an independent UART transmitter for a
// one-byte response. Receiver and transmitter share only clk and reset.
module cmd_link #(
  parameter int BAUD_CYCLES = 2604,
  parameter int BYTE_TMO    = 65536
) (
  input  logic     clk,
  input  logic     RST_n,
  cmd_link_if.slave lnk
);

  localparam int BAUD_W = $clog2(BAUD_CYCLES);
  localparam int TMO_W  = $clog2(BYTE_TMO);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CYCLES - 1);
  // The edge is acted on one cycle after it appears on the second sync flop,
  // so the first countdown is two shorter to land exactly half a bit later.
  localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(BAUD_CYCLES / 2 - 2);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(BYTE_TMO - 1);

  typedef enum logic {RX_IDLE,   RX_RECV}  rx_state_t;
  typedef enum logic {PAIR_HIGH, PAIR_LOW} pair_state_t;
  typedef enum logic {TX_IDLE,   TX_XMIT}  tx_state_t;

  // Synchronizer and edge-history flops
  logic rx_p0, rx_p1, rx_p2;
  logic rx_fall;

  // Receiver
  rx_state_t         rx_state;
  logic [BAUD_W-1:0] rx_baud;
  logic [3:0]        rx_bit;
  logic [7:0]        rx_shift;

  // Byte pairing
  pair_state_t       pair_state;
  logic [7:0]        hi_byte;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [15:0]       cmd_q;
  logic              cmd_rdy_q;

  // Transmitter
  tx_state_t         tx_state;
  logic [BAUD_W-1:0] tx_baud;
  logic [3:0]        tx_bit;
  logic [8:0]        tx_shift;
  logic              tx_q;
  logic              tx_done_q;

  // Bring RX into the clk domain (preset idle-high) and keep one history bit
  always_ff @(posedge clk) begin
    if (!RST_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= lnk.RX;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_fall = rx_p2 & ~rx_p1;

  // Receive UART frames, pair valid bytes into commands, manage cmd_rdy
  always_ff @(posedge clk) begin
    if (!RST_n) begin
      rx_state   <= RX_IDLE;
      rx_baud    <= '0;
      rx_bit     <= '0;
      pair_state <= PAIR_HIGH;
      tmo_cnt    <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      // Clear first; a set later in this block overrides it.
      if (lnk.clr_cmd_rdy)
        cmd_rdy_q <= 1'b0;

      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_RECV;
            rx_baud  <= HALF_LOAD;
            rx_bit   <= '0;
          end
        end
        RX_RECV: begin
          if (rx_baud != '0) begin
            rx_baud <= rx_baud - 1'b1;
          end else begin
            rx_baud <= BAUD_LAST;
            rx_bit  <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
              // A high start sample was only a glitch.
              if (rx_p1)
                rx_state <= RX_IDLE;
            end else if (rx_bit != 4'd9) begin
              rx_shift <= {rx_p1, rx_shift[7:1]};
            end else begin
              rx_state <= RX_IDLE;
              if (!rx_p1) begin
                // Framing error: drop the byte and any half-built pair.
                pair_state <= PAIR_HIGH;
              end else if (pair_state == PAIR_HIGH) begin
                hi_byte    <= rx_shift;
                pair_state <= PAIR_LOW;
                tmo_cnt    <= '0;
                cmd_rdy_q  <= 1'b0;
              end else begin
                cmd_q      <= {hi_byte, rx_shift};
                cmd_rdy_q  <= 1'b1;
                pair_state <= PAIR_HIGH;
              end
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase

      // Waiting for the low byte: give up if its start edge never comes.
      if (pair_state == PAIR_LOW && rx_state == RX_IDLE && !rx_fall) begin
        if (tmo_cnt == TMO_LAST)
          pair_state <= PAIR_HIGH;
        else
          tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Serialize the response byte: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (!RST_n) begin
      tx_state  <= TX_IDLE;
      tx_baud   <= '0;
      tx_bit    <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (lnk.trmt) begin
            // Start bit goes straight to the line; {stop, data} waits behind it.
            tx_shift  <= {1'b1, lnk.resp};
            tx_q      <= 1'b0;
            tx_baud   <= BAUD_LAST;
            tx_bit    <= '0;
            tx_done_q <= 1'b0;
            tx_state  <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_baud != '0) begin
            tx_baud <= tx_baud - 1'b1;
          end else if (tx_bit == 4'd9) begin
            tx_state  <= TX_IDLE;
            tx_done_q <= 1'b1;
            tx_q      <= 1'b1;
          end else begin
            tx_q     <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bit   <= tx_bit + 4'd1;
            tx_baud  <= BAUD_LAST;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign lnk.TX      = tx_q;
  assign lnk.tx_done = tx_done_q;
  assign lnk.cmd     = cmd_q;
  assign lnk.cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_cmd_link.sv
// Bench for cmd_link: timeline model of both UART directions plus directed
// literal checks, with a shortened baud period to keep runs short.
module tb_cmd_link;
  localparam int B   = 32;
  localparam int H   = B / 2;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic RST_n = 1'b0;
  cmd_link_if lnk();

  cmd_link #(.BAUD_CYCLES(B), .BYTE_TMO(TMO)) dut (
    .clk   (clk),
    .RST_n (RST_n),
    .lnk   (lnk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit rx_abort = 1'b0;

  // ---------------- behavioural model ----------------
  // A received frame whose start bit is driven right after posedge k has its
  // synchronized edge at posedge k+2 and its stop sample at k+2+H+9B.
  typedef struct {
    int         p;    // posedge of the stop sample
    int         se;   // posedge of the synchronized start edge
    logic [7:0] b;
    bit         ok;   // stop bit high
  } rx_ev_t;

  rx_ev_t      evq[$];
  logic [15:0] m_cmd;
  bit          m_rdy;
  bit          m_low;
  logic [7:0]  m_hi;
  int          m_last_stop;
  bit          m_tx_busy;
  bit          m_tx_done;
  int          m_tx_s;
  logic [9:0]  m_tx_frame;

  always @(posedge clk) begin
    cyc++;
    if (!RST_n) begin
      m_cmd = 16'h0000;
      m_rdy = 1'b0;
      m_low = 1'b0;
      evq.delete();
      m_tx_busy = 1'b0;
      m_tx_done = 1'b0;
    end else begin
      bit acc;
      rx_ev_t e;
      acc = lnk.trmt && !m_tx_busy;
      if (m_tx_busy && cyc == m_tx_s + 10 * B) begin
        m_tx_busy = 1'b0;
        m_tx_done = 1'b1;
      end
      if (acc) begin
        m_tx_busy  = 1'b1;
        m_tx_done  = 1'b0;
        m_tx_s     = cyc;
        m_tx_frame = {1'b1, lnk.resp, 1'b0};
      end
      if (lnk.clr_cmd_rdy) m_rdy = 1'b0;
      if (evq.size() > 0 && evq[0].p == cyc) begin
        e = evq.pop_front();
        if (!e.ok) begin
          m_low = 1'b0;
        end else begin
          if (m_low && (e.se - m_last_stop) > TMO) m_low = 1'b0;
          if (!m_low) begin
            m_hi = e.b;
            m_low = 1'b1;
            m_rdy = 1'b0;
            m_last_stop = cyc;
          end else begin
            m_cmd = {m_hi, e.b};
            m_rdy = 1'b1;
            m_low = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic exp_tx();
    if (m_tx_busy) return m_tx_frame[(cyc - m_tx_s) / B];
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("model_TX",      {15'd0, lnk.TX},      {15'd0, exp_tx()});
      chk("model_tx_done", {15'd0, lnk.tx_done}, {15'd0, m_tx_done});
      chk("model_cmd",     lnk.cmd,              m_cmd);
      chk("model_cmd_rdy", {15'd0, lnk.cmd_rdy}, {15'd0, m_rdy});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    logic [9:0] bits;
    rx_ev_t ev;
    bits  = {ok, b, 1'b0};
    ev.p  = cyc + 2 + H + 9 * B;
    ev.se = cyc + 2;
    ev.b  = b;
    ev.ok = ok;
    evq.push_back(ev);
    for (int i = 0; i < 10; i++) begin
      lnk.RX = bits[i];
      for (int c = 0; c < B; c++) begin
        tick(1);
        if (rx_abort) begin
          lnk.RX = 1'b1;
          return;
        end
      end
    end
    lnk.RX = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit ok);
    send_frame(b, ok);
    tick(B);
  endtask

  task automatic pulse_trmt(input logic [7:0] r);
    lnk.trmt = 1'b1;
    lnk.resp = r;
    tick(1);
    lnk.trmt = 1'b0;
    lnk.resp = 8'h3C;
  endtask

  // Bound on total run time
  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic exp_bits [10];
    int k0;
    int p_low;
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    lnk.RX = 1'b1;
    lnk.trmt = 1'b0;
    lnk.clr_cmd_rdy = 1'b0;
    lnk.resp = 8'h00;
    RST_n = 1'b0;
    tick(5);
    chk("reset_TX",      {15'd0, lnk.TX},      16'd1);
    chk("reset_cmd",     lnk.cmd,              16'h0000);
    chk("reset_cmd_rdy", {15'd0, lnk.cmd_rdy}, 16'd0);
    chk("reset_tx_done", {15'd0, lnk.tx_done}, 16'd0);
    RST_n = 1'b1;
    tick(1);
    chk("release_TX", {15'd0, lnk.TX}, 16'd1);
    tick(5);

    // Command 0x2000 received while a 0xA5 response is transmitted
    fork
      begin
        send(8'h20, 1'b1);
        send(8'h00, 1'b1);
      end
      begin
        int s;
        int d;
        pulse_trmt(8'hA5);
        s = cyc;
        d = 0;
        while (d <= 10 * B + 1) begin
          tick(1);
          d = cyc - s;
          if (d % B == H && d / B < 10)
            chk("tx_bit_A5", {15'd0, lnk.TX}, {15'd0, exp_bits[d / B]});
          if (d == 122) begin
            lnk.trmt = 1'b1;
            lnk.resp = 8'hFF;
          end
          if (d == 123) begin
            lnk.trmt = 1'b0;
            lnk.resp = 8'h3C;
          end
          if (d == 10 * B - 1) chk("tx_done_early", {15'd0, lnk.tx_done}, 16'd0);
          if (d == 10 * B)     chk("tx_done_rise",  {15'd0, lnk.tx_done}, 16'd1);
        end
      end
    join
    chk("cmd_2000",     lnk.cmd,              16'h2000);
    chk("rdy_2000",     {15'd0, lnk.cmd_rdy}, 16'd1);
    lnk.clr_cmd_rdy = 1'b1;
    tick(1);
    lnk.clr_cmd_rdy = 1'b0;
    chk("clr_rdy",      {15'd0, lnk.cmd_rdy}, 16'd0);
    chk("clr_cmd_hold", lnk.cmd,              16'h2000);

    // Start-bit glitch, then a clean pair
    lnk.RX = 1'b0;
    tick(10);
    lnk.RX = 1'b1;
    tick(2 * B);
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    chk("cmd_1234", lnk.cmd, 16'h1234);

    // Framing error, then a clean pair
    send(8'h55, 1'b0);
    send(8'hAB, 1'b1);
    send(8'hCD, 1'b1);
    chk("cmd_ABCD", lnk.cmd, 16'hABCD);

    // Orphan high byte times out
    send(8'h11, 1'b1);
    tick(TMO + 10);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    chk("cmd_2233", lnk.cmd, 16'h2233);

    // clr_cmd_rdy coincides with the low-byte stop sample
    k0 = cyc;
    p_low = k0 + 11 * B + 2 + H + 9 * B;
    fork
      begin
        send(8'h5E, 1'b1);
        send(8'h6F, 1'b1);
      end
      begin
        for (int w = 0; w < 4000 && cyc < p_low - 1; w++) tick(1);
        if (cyc != p_low - 1) begin
          n_tests++;
          n_fail++;
          $display("FAIL collision_wait: at cycle %0d, required %0d", cyc, p_low - 1);
        end
        lnk.clr_cmd_rdy = 1'b1;
        tick(1);
        lnk.clr_cmd_rdy = 1'b0;
        chk("collision_rdy", {15'd0, lnk.cmd_rdy}, 16'd1);
      end
    join
    chk("cmd_5E6F", lnk.cmd, 16'h5E6F);

    // Reset in the middle of bit 4 of an RX low byte and a TX frame
    send(8'h77, 1'b1);
    fork
      send_frame(8'h88, 1'b1);
      pulse_trmt(8'hC3);
      begin
        tick(4 * B + H - 1);
        RST_n = 1'b0;
        rx_abort = 1'b1;
        tick(3);
        chk("midrst_TX",      {15'd0, lnk.TX},      16'd1);
        chk("midrst_cmd_rdy", {15'd0, lnk.cmd_rdy}, 16'd0);
        chk("midrst_tx_done", {15'd0, lnk.tx_done}, 16'd0);
        chk("midrst_cmd",     lnk.cmd,              16'h0000);
        RST_n = 1'b1;
      end
    join
    rx_abort = 1'b0;
    tick(1);
    chk("postrst_TX", {15'd0, lnk.TX}, 16'd1);
    tick(20 * B);
    chk("postrst_tx_done", {15'd0, lnk.tx_done}, 16'd0);
    chk("postrst_cmd_rdy", {15'd0, lnk.cmd_rdy}, 16'd0);
    send(8'h9A, 1'b1);
    send(8'hBC, 1'b1);
    chk("cmd_9ABC", lnk.cmd, 16'h9ABC);
    chk("rdy_9ABC", {15'd0, lnk.cmd_rdy}, 16'd1);

    tick(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
